// File: rtl/multi_collision_scanner_if.sv
// Bundle of the control, position and result signals of multi_collision_scanner.
// Clock and reset stay plain ports on the module.
//   master : the game side. It drives init/enable, player and enemy state and reads the results.
//   slave  : the scanner. It reads the stimulus and drives c_e_collision, e_hit, hit_count and done.
// Enemy i occupies slice i of every packed enemy bus.
interface multi_collision_scanner_if #(
    parameter int unsigned NUM_ENEMIES = 3
);
    logic                       init;
    logic                       collision_enable;
    logic [8:0]                 char_x;
    logic [7:0]                 char_y;
    logic [2:0]                 direction_char;
    logic [2:0]                 facing_char;
    logic                       attack;
    logic [9*NUM_ENEMIES-1:0]   enemy_x;
    logic [8*NUM_ENEMIES-1:0]   enemy_y;
    logic [3*NUM_ENEMIES-1:0]   direction_enemy;
    logic [NUM_ENEMIES-1:0]     enemy_alive;
    logic [NUM_ENEMIES-1:0]     c_e_collision;
    logic [NUM_ENEMIES-1:0]     e_hit;
    logic [3:0]                 hit_count;
    logic                       done;

    modport master (
        output init, collision_enable, char_x, char_y, direction_char, facing_char, attack,
               enemy_x, enemy_y, direction_enemy, enemy_alive,
        input  c_e_collision, e_hit, hit_count, done
    );

    modport slave (
        input  init, collision_enable, char_x, char_y, direction_char, facing_char, attack,
               enemy_x, enemy_y, direction_enemy, enemy_alive,
        output c_e_collision, e_hit, hit_count, done
    );
endinterface

// File: rtl/multi_collision_scanner.sv
// Time-multiplexed player/enemy collision and sword-hit scanner.
// Each scan snapshots the player and all enemies, then runs one enemy per cycle through a
// single overlap engine. The engine result is registered before it reaches the shadow vectors.
// done and the results therefore appear NUM_ENEMIES+1 edges after enable is sampled.
// Ports:
//   clock : system clock
//   reset : asynchronous, active-low reset
//   bus   : slave side of multi_collision_scanner_if (control, positions, results)
// Optional feature: define HIT_COOLDOWN_EN for per-enemy hit immunity of COOLDOWN_SCANS scans.
module multi_collision_scanner #(
    parameter int unsigned NUM_ENEMIES    = 3,
    parameter int unsigned CHAR_W         = 16,
    parameter int unsigned CHAR_H         = 16,
    parameter int unsigned ENEMY_W        = 16,
    parameter int unsigned ENEMY_H        = 16,
    parameter int unsigned SWORD_LEN      = 12,
    parameter int unsigned STEP           = 1,
    parameter int unsigned COOLDOWN_SCANS = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    multi_collision_scanner_if.slave bus
);
    localparam int unsigned IdxW = $clog2(NUM_ENEMIES + 1);
    localparam int unsigned N    = NUM_ENEMIES;

    // 11-bit signed coordinates: predictions and sword boxes may go negative without wrapping.
    typedef logic signed [10:0] coord_t;
    localparam coord_t CharW  = coord_t'(CHAR_W);
    localparam coord_t CharH  = coord_t'(CHAR_H);
    localparam coord_t EnemyW = coord_t'(ENEMY_W);
    localparam coord_t EnemyH = coord_t'(ENEMY_H);
    localparam coord_t SwordL = coord_t'(SWORD_LEN);
    localparam coord_t Step   = coord_t'(STEP);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    function automatic coord_t move_x(input coord_t x, input logic [2:0] dir);
        case (dir)
            3'd3:    return x - Step;
            3'd4:    return x + Step;
            default: return x;
        endcase
    endfunction

    function automatic coord_t move_y(input coord_t y, input logic [2:0] dir);
        case (dir)
            3'd1:    return y - Step;
            3'd2:    return y + Step;
            default: return y;
        endcase
    endfunction

    // Strict inequalities: boxes that only touch do not overlap.
    function automatic logic overlap(input coord_t ax, input coord_t ay, input coord_t aw,
                                     input coord_t ah, input coord_t bx, input coord_t by,
                                     input coord_t bw, input coord_t bh);
        return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
    endfunction

    state_e                 state_q, state_d;
    logic [8:0]             cx_q, cx_d;
    logic [7:0]             cy_q, cy_d;
    logic [2:0]             cdir_q, cdir_d, face_q, face_d;
    logic                   atk_q, atk_d;
    logic [9*N-1:0]         ex_q, ex_d;
    logic [8*N-1:0]         ey_q, ey_d;
    logic [3*N-1:0]         edir_q, edir_d;
    logic [N-1:0]           alive_q, alive_d;
    logic [IdxW-1:0]        idx_q, idx_d, stg_idx_q, stg_idx_d;
    logic                   stg_vld_q, stg_vld_d, stg_col_q, stg_col_d, stg_hit_q, stg_hit_d;
    logic [N-1:0]           col_sh_q, col_sh_d, hit_sh_q, hit_sh_d;
    logic [N-1:0]           col_q, col_d, hit_q, hit_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [N-1:0]           cool_mask;
    logic                   publish;

    // Engine operands for the enemy selected by idx_q.
    logic [8:0]             sel_x;
    logic [7:0]             sel_y;
    logic [2:0]             sel_dir;
    logic                   sel_alive, sel_cool, sword_vld, eval_col, eval_hit;
    coord_t                 cur_x, cur_y, sx, sy, sw, sh;

    always_comb begin
        sel_x     = '0;
        sel_y     = '0;
        sel_dir   = '0;
        sel_alive = 1'b0;
        sel_cool  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IdxW'(i)) begin
                sel_x     = ex_q[9*i +: 9];
                sel_y     = ey_q[8*i +: 8];
                sel_dir   = edir_q[3*i +: 3];
                sel_alive = alive_q[i];
                sel_cool  = cool_mask[i];
            end
        end
        cur_x     = coord_t'({2'b00, cx_q});
        cur_y     = coord_t'({3'b000, cy_q});
        sword_vld = atk_q;
        sx        = cur_x;
        sy        = cur_y;
        sw        = CharW;
        sh        = CharH;
        case (face_q)
            3'd1:    begin sy = cur_y - SwordL; sh = SwordL; end
            3'd2:    begin sy = cur_y + CharH;  sh = SwordL; end
            3'd3:    begin sx = cur_x - SwordL; sw = SwordL; end
            3'd4:    begin sx = cur_x + CharW;  sw = SwordL; end
            default: sword_vld = 1'b0;
        endcase
        eval_col = sel_alive &&
                   overlap(move_x(cur_x, cdir_q), move_y(cur_y, cdir_q), CharW, CharH,
                           move_x(coord_t'({2'b00, sel_x}), sel_dir),
                           move_y(coord_t'({3'b000, sel_y}), sel_dir), EnemyW, EnemyH);
        eval_hit = sword_vld && sel_alive && !sel_cool &&
                   overlap(sx, sy, sw, sh, coord_t'({2'b00, sel_x}), coord_t'({3'b000, sel_y}),
                           EnemyW, EnemyH);
    end

    always_comb begin
        state_d   = state_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        cdir_d    = cdir_q;
        face_d    = face_q;
        atk_d     = atk_q;
        ex_d      = ex_q;
        ey_d      = ey_q;
        edir_d    = edir_q;
        alive_d   = alive_q;
        idx_d     = idx_q;
        stg_vld_d = stg_vld_q;
        stg_idx_d = stg_idx_q;
        stg_col_d = stg_col_q;
        stg_hit_d = stg_hit_q;
        col_sh_d  = col_sh_q;
        hit_sh_d  = hit_sh_q;
        col_d     = col_q;
        hit_d     = hit_q;
        cnt_d     = cnt_q;
        publish   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.collision_enable) begin
                    state_d   = StScan;
                    cx_d      = bus.char_x;
                    cy_d      = bus.char_y;
                    cdir_d    = bus.direction_char;
                    face_d    = bus.facing_char;
                    atk_d     = bus.attack;
                    ex_d      = bus.enemy_x;
                    ey_d      = bus.enemy_y;
                    edir_d    = bus.direction_enemy;
                    alive_d   = bus.enemy_alive;
                    col_sh_d  = '0;
                    hit_sh_d  = '0;
                    idx_d     = '0;
                    stg_vld_d = 1'b0;
                end
            end
            StScan: begin
                // Issue stage: idx_q == N means every enemy has been issued.
                stg_vld_d = 1'b0;
                if (idx_q != IdxW'(N)) begin
                    stg_vld_d = 1'b1;
                    stg_idx_d = idx_q;
                    stg_col_d = eval_col;
                    stg_hit_d = eval_hit;
                    idx_d     = idx_q + 1'b1;
                end
                // Retire stage: write the registered result into the shadows.
                if (stg_vld_q) begin
                    for (int i = 0; i < N; i++) begin
                        if (stg_idx_q == IdxW'(i)) begin
                            col_sh_d[i] = stg_col_q;
                            hit_sh_d[i] = stg_hit_q;
                        end
                    end
                    if (stg_idx_q == IdxW'(N - 1)) begin
                        state_d = StDone;
                        publish = 1'b1;
                        col_d   = col_sh_d;
                        hit_d   = hit_sh_d;
                        cnt_d   = '0;
                        for (int i = 0; i < N; i++) begin
                            cnt_d = cnt_d + 4'(hit_sh_d[i]);
                        end
                    end
                end
            end
            StDone: begin
                if (!bus.collision_enable) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (bus.init) begin
            state_d   = StIdle;
            idx_d     = '0;
            stg_vld_d = 1'b0;
            col_sh_d  = '0;
            hit_sh_d  = '0;
            col_d     = '0;
            hit_d     = '0;
            cnt_d     = '0;
            publish   = 1'b0;
        end
    end

`ifdef HIT_COOLDOWN_EN
    localparam int unsigned CdW = (COOLDOWN_SCANS > 0) ? $clog2(COOLDOWN_SCANS + 1) : 1;
    logic [N-1:0][CdW-1:0] cd_q, cd_d;

    always_comb begin
        cd_d = cd_q;
        for (int i = 0; i < N; i++) begin
            cool_mask[i] = (cd_q[i] != '0);
            if (publish) begin
                if (hit_d[i]) begin
                    cd_d[i] = CdW'(COOLDOWN_SCANS);
                end else if (cd_q[i] != '0) begin
                    cd_d[i] = cd_q[i] - 1'b1;
                end
            end
        end
        if (bus.init) begin
            cd_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cd_q <= '0;
        end else begin
            cd_q <= cd_d;
        end
    end
`else
    assign cool_mask = '0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cx_q      <= '0;
            cy_q      <= '0;
            cdir_q    <= '0;
            face_q    <= '0;
            atk_q     <= 1'b0;
            ex_q      <= '0;
            ey_q      <= '0;
            edir_q    <= '0;
            alive_q   <= '0;
            idx_q     <= '0;
            stg_vld_q <= 1'b0;
            stg_idx_q <= '0;
            stg_col_q <= 1'b0;
            stg_hit_q <= 1'b0;
            col_sh_q  <= '0;
            hit_sh_q  <= '0;
            col_q     <= '0;
            hit_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            cdir_q    <= cdir_d;
            face_q    <= face_d;
            atk_q     <= atk_d;
            ex_q      <= ex_d;
            ey_q      <= ey_d;
            edir_q    <= edir_d;
            alive_q   <= alive_d;
            idx_q     <= idx_d;
            stg_vld_q <= stg_vld_d;
            stg_idx_q <= stg_idx_d;
            stg_col_q <= stg_col_d;
            stg_hit_q <= stg_hit_d;
            col_sh_q  <= col_sh_d;
            hit_sh_q  <= hit_sh_d;
            col_q     <= col_d;
            hit_q     <= hit_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.c_e_collision = col_q;
    assign bus.e_hit         = hit_q;
    assign bus.hit_count     = cnt_q;
    assign bus.done          = (state_q == StDone);
endmodule

// File: tb/tb_multi_collision_scanner.sv
// Self-checking bench for multi_collision_scanner with 8 enemy channels.
// Expected results come from a box-geometry reference model working on plain integers.
module tb_multi_collision_scanner;
    localparam int N    = 8;
    localparam int CW   = 16;
    localparam int CH   = 16;
    localparam int EW   = 16;
    localparam int EH   = 16;
    localparam int SL   = 12;
    localparam int STP  = 1;
    localparam int COOL = 4;
`ifdef HIT_COOLDOWN_EN
    localparam bit CD_EN = 1'b1;
`else
    localparam bit CD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    multi_collision_scanner_if #(.NUM_ENEMIES(N)) bus ();

    multi_collision_scanner #(
        .NUM_ENEMIES   (N),
        .CHAR_W        (CW),
        .CHAR_H        (CH),
        .ENEMY_W       (EW),
        .ENEMY_H       (EH),
        .SWORD_LEN     (SL),
        .STEP          (STP),
        .COOLDOWN_SCANS(COOL)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Scenario state; model and DUT stimulus are both derived from it.
    int cx, cy, dc, fc;
    bit atk;
    int ex[N];
    int ey[N];
    int ed[N];
    logic [N-1:0] alive;
    int cd[N];
    logic [N-1:0] exp_col, exp_hit;

    function automatic int dxf(input int d);
        return (d == 3) ? -STP : (d == 4) ? STP : 0;
    endfunction

    function automatic int dyf(input int d);
        return (d == 1) ? -STP : (d == 2) ? STP : 0;
    endfunction

    function automatic bit ov(input int ax, input int ay, input int aw, input int ah,
                              input int bx, input int by, input int bw, input int bh);
        return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
    endfunction

    // Expected result of one completed scan; also ages the cooldown model.
    task automatic model_scan(output logic [N-1:0] col, output logic [N-1:0] hit);
        int sx, sy, sw, sh;
        bit sv;
        sx = cx; sy = cy; sw = CW; sh = CH; sv = atk;
        case (fc)
            1: begin sy = cy - SL; sh = SL; end
            2: begin sy = cy + CH; sh = SL; end
            3: begin sx = cx - SL; sw = SL; end
            4: begin sx = cx + CW; sw = SL; end
            default: sv = 1'b0;
        endcase
        for (int i = 0; i < N; i++) begin
            col[i] = alive[i] && ov(cx + dxf(dc), cy + dyf(dc), CW, CH,
                                    ex[i] + dxf(ed[i]), ey[i] + dyf(ed[i]), EW, EH);
            hit[i] = sv && alive[i] && ov(sx, sy, sw, sh, ex[i], ey[i], EW, EH) && (cd[i] == 0);
            if (CD_EN) begin
                if (hit[i]) cd[i] = COOL;
                else if (cd[i] > 0) cd[i] = cd[i] - 1;
            end
        end
    endtask

    task automatic apply();
        bus.char_x         = 9'(cx);
        bus.char_y         = 8'(cy);
        bus.direction_char = 3'(dc);
        bus.facing_char    = 3'(fc);
        bus.attack         = atk;
        bus.enemy_alive    = alive;
        for (int i = 0; i < N; i++) begin
            bus.enemy_x[9*i +: 9]         = 9'(ex[i]);
            bus.enemy_y[8*i +: 8]         = 8'(ey[i]);
            bus.direction_enemy[3*i +: 3] = 3'(ed[i]);
        end
    endtask

    task automatic base_scene();
        cx = 100; cy = 100; dc = 0; fc = 0; atk = 1'b0;
        alive = '0;
        for (int i = 0; i < N; i++) begin
            ex[i] = 400; ey[i] = 200; ed[i] = 0;
        end
        ex[0] = 110; ey[0] = 100;
        ex[1] = 116; ey[1] = 100;
        ex[2] = 200; ey[2] = 50;
        alive[2:0] = 3'b111;
    endtask

    task automatic clear_cd_model();
        for (int i = 0; i < N; i++) cd[i] = 0;
    endtask

    // Raises enable and returns the edge index after which done was first seen (40 = timeout).
    task automatic run_scan(output int n);
        bus.collision_enable = 1'b1;
        @(negedge clk);
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic end_scan();
        bus.collision_enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.init = 1'b0;
        bus.collision_enable = 1'b0;
        base_scene();
        apply();
        clear_cd_model();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.c_e_collision !== '0 || bus.e_hit !== '0 ||
            bus.hit_count !== 4'd0) begin
            $display("FAIL reset_state: done=%b col=%b hit=%b cnt=%0d required all zero",
                     bus.done, bus.c_e_collision, bus.e_hit, bus.hit_count);
            fails++;
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            $display("FAIL idle_no_scan: done=%b required 0", bus.done);
            fails++;
        end
    endtask

    task automatic test_overlap();
        int n;
        base_scene();
        apply();
        model_scan(exp_col, exp_hit);
        run_scan(n);
        checks++;
        if (n !== N + 1) begin
            $display("FAIL overlap_latency: got %0d required %0d", n, N + 1);
            fails++;
        end
        checks++;
        if (bus.c_e_collision !== 8'b0000_0001 || bus.hit_count !== 4'd0) begin
            $display("FAIL overlap_edge: col=%b cnt=%0d required col=00000001 cnt=0",
                     bus.c_e_collision, bus.hit_count);
            fails++;
        end
        end_scan();
        checks++;
        if (bus.done !== 1'b0 || bus.c_e_collision !== exp_col) begin
            $display("FAIL idle_hold: done=%b col=%b required done=0 col=%b",
                     bus.done, bus.c_e_collision, exp_col);
            fails++;
        end
    endtask

    task automatic test_prediction();
        int n;
        base_scene();
        dc = 4;
        apply();
        model_scan(exp_col, exp_hit);
        run_scan(n);
        checks++;
        if (bus.c_e_collision !== 8'b0000_0011) begin
            $display("FAIL prediction: col=%b required 00000011", bus.c_e_collision);
            fails++;
        end
        end_scan();
    endtask

    task automatic test_sword();
        int n;
        base_scene();
        atk = 1'b1; fc = 4;
        ex[0] = 120; ey[0] = 100;
        ex[1] = 120; ey[1] = 100; alive[1] = 1'b0;
        apply();
        model_scan(exp_col, exp_hit);
        run_scan(n);
        checks++;
        if (bus.e_hit !== 8'b0000_0001 || bus.hit_count !== 4'd1) begin
            $display("FAIL sword_alive: hit=%b cnt=%0d required hit=00000001 cnt=1",
                     bus.e_hit, bus.hit_count);
            fails++;
        end
        checks++;
        if (bus.c_e_collision !== exp_col) begin
            $display("FAIL sword_col: col=%b required %b", bus.c_e_collision, exp_col);
            fails++;
        end
        end_scan();
    endtask

    task automatic test_snapshot();
        int n;
        base_scene();
        alive = '1;
        apply();
        model_scan(exp_col, exp_hit);
        bus.collision_enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ex[0] = 300; ey[0] = 10; cx = 10;
        apply();
        n = 1;
        while (bus.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== N + 1) begin
            $display("FAIL snapshot_latency: got %0d required %0d", n, N + 1);
            fails++;
        end
        checks++;
        if (bus.c_e_collision !== exp_col || bus.e_hit !== exp_hit) begin
            $display("FAIL snapshot_result: col=%b hit=%b required col=%b hit=%b",
                     bus.c_e_collision, bus.e_hit, exp_col, exp_hit);
            fails++;
        end
        end_scan();
        model_scan(exp_col, exp_hit);
        run_scan(n);
        checks++;
        if (bus.c_e_collision !== exp_col) begin
            $display("FAIL snapshot_rescan: col=%b required %b", bus.c_e_collision, exp_col);
            fails++;
        end
        end_scan();
    endtask

    task automatic test_cooldown();
        int n;
        logic [5:0] seq;
        seq = CD_EN ? 6'b100001 : 6'b111111;
        bus.init = 1'b1;
        @(negedge clk);
        bus.init = 1'b0;
        clear_cd_model();
        base_scene();
        atk = 1'b1; fc = 4;
        ex[0] = 120; ey[0] = 100;
        apply();
        for (int s = 0; s < 6; s++) begin
            model_scan(exp_col, exp_hit);
            run_scan(n);
            checks++;
            if (bus.e_hit[0] !== seq[5-s] || bus.e_hit !== exp_hit) begin
                $display("FAIL cooldown_scan%0d: hit=%b required bit0=%b vector=%b",
                         s, bus.e_hit, seq[5-s], exp_hit);
                fails++;
            end
            end_scan();
        end
    endtask

    task automatic test_init();
        int n;
        base_scene();
        apply();
        model_scan(exp_col, exp_hit);
        run_scan(n);
        end_scan();
        bus.collision_enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.init = 1'b1;
        bus.collision_enable = 1'b0;
        @(negedge clk);
        bus.init = 1'b0;
        clear_cd_model();
        checks++;
        if (bus.done !== 1'b0 || bus.c_e_collision !== '0 || bus.e_hit !== '0 ||
            bus.hit_count !== 4'd0) begin
            $display("FAIL init_clear: done=%b col=%b hit=%b cnt=%0d required all zero",
                     bus.done, bus.c_e_collision, bus.e_hit, bus.hit_count);
            fails++;
        end
        repeat (N + 2) @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.c_e_collision !== '0) begin
            $display("FAIL init_stays_idle: done=%b col=%b required 0", bus.done,
                     bus.c_e_collision);
            fails++;
        end
        model_scan(exp_col, exp_hit);
        run_scan(n);
        checks++;
        if (n !== N + 1 || bus.c_e_collision !== exp_col) begin
            $display("FAIL init_recover: latency=%0d col=%b required %0d %b",
                     n, bus.c_e_collision, N + 1, exp_col);
            fails++;
        end
        end_scan();
    endtask

    task automatic test_reset_midscan();
        int n;
        base_scene();
        apply();
        model_scan(exp_col, exp_hit);
        run_scan(n);
        end_scan();
        bus.collision_enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.done !== 1'b0 || bus.c_e_collision !== '0 || bus.hit_count !== 4'd0) begin
            $display("FAIL async_reset: done=%b col=%b cnt=%0d required all zero",
                     bus.done, bus.c_e_collision, bus.hit_count);
            fails++;
        end
        bus.collision_enable = 1'b0;
        clear_cd_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_scan(exp_col, exp_hit);
        run_scan(n);
        checks++;
        if (n !== N + 1 || bus.c_e_collision !== exp_col) begin
            $display("FAIL reset_recover: latency=%0d col=%b required %0d %b",
                     n, bus.c_e_collision, N + 1, exp_col);
            fails++;
        end
        end_scan();
    endtask

    // Random scenes, half of them with enable dropped during the scan.
    task automatic test_random();
        int n;
        bit early;
        for (int t = 0; t < 30; t++) begin
            cx = $urandom_range(0, 200);
            cy = $urandom_range(0, 200);
            dc = $urandom_range(0, 7);
            fc = $urandom_range(0, 7);
            atk = 1'($urandom_range(0, 1));
            alive = N'($urandom);
            for (int i = 0; i < N; i++) begin
                ex[i] = cx + $urandom_range(0, 60) - 30;
                ey[i] = cy + $urandom_range(0, 60) - 30;
                if (ex[i] < 0) ex[i] = 0;
                if (ey[i] < 0) ey[i] = 0;
                if (ey[i] > 255) ey[i] = 255;
                ed[i] = $urandom_range(0, 7);
            end
            early = 1'($urandom_range(0, 1));
            apply();
            model_scan(exp_col, exp_hit);
            bus.collision_enable = 1'b1;
            @(negedge clk);
            if (early) bus.collision_enable = 1'b0;
            n = 0;
            while (bus.done !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n !== N + 1 || bus.c_e_collision !== exp_col || bus.e_hit !== exp_hit ||
                bus.hit_count !== 4'($countones(exp_hit))) begin
                $display("FAIL random%0d: lat=%0d col=%b hit=%b cnt=%0d required %0d %b %b %0d",
                         t, n, bus.c_e_collision, bus.e_hit, bus.hit_count, N + 1, exp_col,
                         exp_hit, $countones(exp_hit));
                fails++;
            end
            if (early) begin
                @(negedge clk);
                checks++;
                if (bus.done !== 1'b0) begin
                    $display("FAIL done_pulse%0d: done=%b required 0", t, bus.done);
                    fails++;
                end
            end else begin
                end_scan();
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_overlap();
        test_prediction();
        test_sword();
        test_snapshot();
        test_cooldown();
        test_init();
        test_reset_midscan();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
